muldiv_hilo_ctrl: RTL and testbench

- Sequencing controller for the EX-stage multiply/divide resources and the architectural HI/LO register.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO ops from EX and launches the multi-cycle radix-2 divider.
- Generates the EX stall while a division is in flight and cancels the divider on flush.
- Commits results to HI/LO only when the owning instruction leaves EX unflushed.

---
 rtl/muldiv_hilo_ctrl.sv | 160 ++++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO sequencing controller: commits MULT/MT* results directly and runs the
// external radix-2 divider with EX stall, flush cancel and a busy timeout.
module muldiv_hilo_ctrl #(
  parameter int unsigned DIV_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid_e,
  input  logic [2:0]  op_e,
  input  logic [31:0] src_a_e,
  input  logic [31:0] src_b_e,
  input  logic        flush_e,
  input  logic        stall_ext_e,
  output logic        stall_e,
  output logic        div_start,
  output logic        div_sign,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_cancel,
  input  logic        div_done,
  input  logic [63:0] div_result,
  input  logic [63:0] mul_result,
  output logic [63:0] hilo,
  output logic        div_timeout
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       res_q, res_d;
  logic [63:0]       hilo_q, hilo_d;
  logic [31:0]       div_a_q, div_a_d;
  logic [31:0]       div_b_q, div_b_d;
  logic              div_sign_q, div_sign_d;
  logic              div_start_q, div_start_d;
  logic              div_cancel_q, div_cancel_d;
  logic              div_timeout_q, div_timeout_d;

  logic is_div;
  logic adv;

  assign is_div = op_valid_e & ((op_e == OP_DIV) | (op_e == OP_DIVU));
  assign adv    = ~stall_ext_e & ~flush_e;

  // State register and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      res_q         <= '0;
      hilo_q        <= '0;
      div_a_q       <= '0;
      div_b_q       <= '0;
      div_sign_q    <= 1'b0;
      div_start_q   <= 1'b0;
      div_cancel_q  <= 1'b0;
      div_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      res_q         <= res_d;
      hilo_q        <= hilo_d;
      div_a_q       <= div_a_d;
      div_b_q       <= div_b_d;
      div_sign_q    <= div_sign_d;
      div_start_q   <= div_start_d;
      div_cancel_q  <= div_cancel_d;
      div_timeout_q <= div_timeout_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    res_d         = res_q;
    hilo_d        = hilo_q;
    div_a_d       = div_a_q;
    div_b_d       = div_b_q;
    div_sign_d    = div_sign_q;
    div_start_d   = 1'b0;
    div_cancel_d  = 1'b0;
    div_timeout_d = div_timeout_q;
    stall_e       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (is_div && !flush_e) begin
          // Hold the divide in EX on the accept cycle itself
          stall_e     = 1'b1;
          div_a_d     = src_a_e;
          div_b_d     = src_b_e;
          div_sign_d  = (op_e == OP_DIV);
          div_start_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_BUSY;
        end else if (op_valid_e && adv) begin
          case (op_e)
            OP_MULT, OP_MULTU: hilo_d = mul_result;
            OP_MTHI:           hilo_d = {src_a_e, hilo_q[31:0]};
            OP_MTLO:           hilo_d = {hilo_q[63:32], src_a_e};
            default:           hilo_d = hilo_q;
          endcase
        end
      end

      S_BUSY: begin
        stall_e = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        // Flush wins over a same-cycle div_done
        if (flush_e) begin
          div_cancel_d = 1'b1;
          state_d      = S_IDLE;
        end else if (div_done) begin
          res_d   = div_result;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          div_cancel_d  = 1'b1;
          div_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end
      end

      S_DONE: begin
        if (flush_e) begin
          state_d = S_IDLE;
        end else if (!stall_ext_e) begin
          hilo_d  = res_q;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign div_start   = div_start_q;
  assign div_sign    = div_sign_q;
  assign div_a       = div_a_q;
  assign div_b       = div_b_q;
  assign div_cancel  = div_cancel_q;
  assign hilo        = hilo_q;
  assign div_timeout = div_timeout_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Scenario bench for muldiv_hilo_ctrl: emulates the EX pipeline slot and a
// behavioural divider, with expected HI/LO values queued at stimulus time.
module tb_muldiv_hilo_ctrl;

  logic        clk;
  logic        rst;
  logic        op_valid_e;
  logic [2:0]  op_e;
  logic [31:0] src_a_e;
  logic [31:0] src_b_e;
  logic        flush_e;
  logic        stall_ext_e;
  logic        stall_e;
  logic        div_start;
  logic        div_sign;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_cancel;
  logic        div_done;
  logic [63:0] div_result;
  logic [63:0] mul_result;
  logic [63:0] hilo;
  logic        div_timeout;

  int n_chk;
  int n_pass;
  logic [63:0] exp_q[$];

  muldiv_hilo_ctrl #(.DIV_TIMEOUT(64), .CNT_W(7)) dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid_e  (op_valid_e),
    .op_e        (op_e),
    .src_a_e     (src_a_e),
    .src_b_e     (src_b_e),
    .flush_e     (flush_e),
    .stall_ext_e (stall_ext_e),
    .stall_e     (stall_e),
    .div_start   (div_start),
    .div_sign    (div_sign),
    .div_a       (div_a),
    .div_b       (div_b),
    .div_cancel  (div_cancel),
    .div_done    (div_done),
    .div_result  (div_result),
    .mul_result  (mul_result),
    .hilo        (hilo),
    .div_timeout (div_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural divider: {remainder, quotient}; divide-by-zero gives {a, all-ones}
  function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Drives one divide through the EX slot; the instruction leaves on an unstalled or flushed cycle.
  task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int flush_at, input int ext_from, input int ext_n,
                         input int run_min,
                         output int stalls, output int starts, output int cancels,
                         output int early, output logic [31:0] ca, output logic [31:0] cb,
                         output logic cs, output logic timed_out);
    logic [63:0] h0;
    logic        leave;
    int          cyc;
    h0 = hilo;
    stalls = 0; starts = 0; cancels = 0; early = 0;
    ca = '0; cb = '0; cs = 1'b0; timed_out = 1'b0;
    cyc = 0;
    op_valid_e = 1'b1; op_e = op; src_a_e = a; src_b_e = b;
    while (1'b1) begin
      div_done    = (cyc == lat);
      div_result  = (cyc == lat) ? div_model(ca, cb, cs) : 64'hBAD0_BAD0_BAD0_BAD0;
      flush_e     = (cyc == flush_at) && op_valid_e;
      stall_ext_e = (cyc >= ext_from) && (cyc < ext_from + ext_n);
      @(negedge clk);
      if (stall_e) stalls++;
      if (div_start) begin
        starts++;
        ca = div_a; cb = div_b; cs = div_sign;
      end
      if (div_cancel) cancels++;
      if (op_valid_e && (hilo !== h0)) early++;
      leave = op_valid_e && (flush_e || (!stall_e && !stall_ext_e));
      @(posedge clk);
      #1;
      if (leave) op_valid_e = 1'b0;
      cyc++;
      if (!op_valid_e && cyc > run_min) break;
      if (cyc > 400) begin
        timed_out = 1'b1;
        break;
      end
    end
    op_valid_e = 1'b0; div_done = 1'b0; flush_e = 1'b0; stall_ext_e = 1'b0;
  endtask

  // Single-cycle non-divide op in EX
  task automatic one_op(input logic [2:0] op, input logic [31:0] a, input logic [63:0] mres,
                        input logic ext, output logic st);
    op_valid_e = 1'b1; op_e = op; src_a_e = a; src_b_e = 32'd5;
    mul_result = mres; stall_ext_e = ext; flush_e = 1'b0;
    @(negedge clk);
    st = stall_e;
    @(posedge clk);
    #1;
    op_valid_e = 1'b0; stall_ext_e = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_chk++; if (hilo !== 64'd0) $display("FAIL reset_hilo: got %h exp 0", hilo); else n_pass++;
    n_chk++; if (stall_e !== 1'b0) $display("FAIL reset_stall: got %b exp 0", stall_e); else n_pass++;
    n_chk++; if ({div_start, div_cancel, div_sign, div_timeout} !== 4'b0)
      $display("FAIL reset_flags: got %b exp 0000", {div_start, div_cancel, div_sign, div_timeout});
    else n_pass++;
    n_chk++; if ({div_a, div_b} !== 64'd0) $display("FAIL reset_ops: got %h exp 0", {div_a, div_b}); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_div;
    int st, sr, cn, er;
    logic [31:0] ca, cb;
    logic cs, to;
    logic [63:0] e;
    exp_q.push_back(64'h00000002_0000000E);
    run_div(3'd2, 32'd100, 32'd7, 33, -1, -1, 0, 0, st, sr, cn, er, ca, cb, cs, to);
    e = exp_q.pop_front();
    n_chk++; if (to !== 1'b0) $display("FAIL div_hang: got %b exp 0", to); else n_pass++;
    n_chk++; if (st !== 34) $display("FAIL div_stall_cycles: got %0d exp 34", st); else n_pass++;
    n_chk++; if (sr !== 1) $display("FAIL div_start_pulses: got %0d exp 1", sr); else n_pass++;
    n_chk++; if ({ca, cb, cs} !== {32'd100, 32'd7, 1'b1})
      $display("FAIL div_operands: got %h/%h/%b exp 64/7/1", ca, cb, cs); else n_pass++;
    n_chk++; if (er !== 0) $display("FAIL div_early_write: got %0d exp 0", er); else n_pass++;
    n_chk++; if (hilo !== e) $display("FAIL div_hilo: got %h exp %h", hilo, e); else n_pass++;
  endtask

  task automatic test_divu;
    int st, sr, cn, er;
    logic [31:0] ca, cb;
    logic cs, to;
    logic [63:0] e;
    exp_q.push_back(64'h00000001_7FFFFFFF);
    run_div(3'd3, 32'hFFFF_FFFF, 32'd2, 33, -1, -1, 0, 0, st, sr, cn, er, ca, cb, cs, to);
    e = exp_q.pop_front();
    n_chk++; if (to !== 1'b0) $display("FAIL divu_hang: got %b exp 0", to); else n_pass++;
    n_chk++; if (cs !== 1'b0) $display("FAIL divu_sign: got %b exp 0", cs); else n_pass++;
    n_chk++; if (st !== 34) $display("FAIL divu_stall_cycles: got %0d exp 34", st); else n_pass++;
    n_chk++; if (hilo !== e) $display("FAIL divu_hilo: got %h exp %h", hilo, e); else n_pass++;
  endtask

  task automatic test_mult;
    logic st;
    logic [63:0] e;
    exp_q.push_back(64'hFFFFFFFF_FFFFFFF1);
    one_op(3'd0, 32'hFFFF_FFFD, 64'hFFFFFFFF_FFFFFFF1, 1'b0, st);
    e = exp_q.pop_front();
    n_chk++; if (st !== 1'b0) $display("FAIL mult_stall: got %b exp 0", st); else n_pass++;
    n_chk++; if (hilo !== e) $display("FAIL mult_hilo: got %h exp %h", hilo, e); else n_pass++;
    // An externally stalled MULTU must not write
    exp_q.push_back(64'hFFFFFFFF_FFFFFFF1);
    one_op(3'd1, 32'd7, 64'h0000_0000_0000_0023, 1'b1, st);
    e = exp_q.pop_front();
    n_chk++; if (hilo !== e) $display("FAIL multu_stalled_hilo: got %h exp %h", hilo, e); else n_pass++;
  endtask

  task automatic test_mthi_mtlo;
    logic st;
    logic [63:0] e;
    exp_q.push_back(64'hDEADBEEF_FFFFFFF1);
    exp_q.push_back(64'hDEADBEEF_12345678);
    one_op(3'd4, 32'hDEAD_BEEF, 64'd0, 1'b0, st);
    e = exp_q.pop_front();
    n_chk++; if (hilo !== e) $display("FAIL mthi_hilo: got %h exp %h", hilo, e); else n_pass++;
    one_op(3'd5, 32'h1234_5678, 64'd0, 1'b0, st);
    e = exp_q.pop_front();
    n_chk++; if (hilo !== e) $display("FAIL mtlo_hilo: got %h exp %h", hilo, e); else n_pass++;
  endtask

  task automatic test_flush_busy;
    int st, sr, cn, er;
    logic [31:0] ca, cb;
    logic cs, to, s1;
    logic [63:0] e;
    exp_q.push_back(64'hDEADBEEF_12345678);
    run_div(3'd2, 32'd50, 32'd3, 40, 10, -1, 0, 42, st, sr, cn, er, ca, cb, cs, to);
    e = exp_q.pop_front();
    n_chk++; if (to !== 1'b0) $display("FAIL flush_hang: got %b exp 0", to); else n_pass++;
    n_chk++; if (cn !== 1) $display("FAIL flush_cancel_pulses: got %0d exp 1", cn); else n_pass++;
    n_chk++; if (st !== 11) $display("FAIL flush_stall_cycles: got %0d exp 11", st); else n_pass++;
    n_chk++; if (hilo !== e) $display("FAIL flush_hilo: got %h exp %h", hilo, e); else n_pass++;
    // Back in IDLE after a stray div_done: MTLO must go straight through
    exp_q.push_back(64'hDEADBEEF_A5A5A5A5);
    one_op(3'd5, 32'hA5A5_A5A5, 64'd0, 1'b0, s1);
    e = exp_q.pop_front();
    n_chk++; if ({s1, hilo} !== {1'b0, e}) $display("FAIL flush_then_mtlo: got %b/%h exp 0/%h", s1, hilo, e);
    else n_pass++;
  endtask

  task automatic test_timeout;
    int st, sr, cn, er;
    logic [31:0] ca, cb;
    logic cs, to;
    logic [63:0] e;
    exp_q.push_back(64'hDEADBEEF_A5A5A5A5);
    run_div(3'd3, 32'd77, 32'd3, -1, 65, -1, 0, 0, st, sr, cn, er, ca, cb, cs, to);
    e = exp_q.pop_front();
    n_chk++; if (to !== 1'b0) $display("FAIL timeout_hang: got %b exp 0", to); else n_pass++;
    n_chk++; if (st !== 65) $display("FAIL timeout_stall_cycles: got %0d exp 65", st); else n_pass++;
    n_chk++; if (cn !== 1) $display("FAIL timeout_cancel_pulses: got %0d exp 1", cn); else n_pass++;
    n_chk++; if (div_timeout !== 1'b1) $display("FAIL timeout_flag: got %b exp 1", div_timeout); else n_pass++;
    n_chk++; if (hilo !== e) $display("FAIL timeout_hilo: got %h exp %h", hilo, e); else n_pass++;
  endtask

  task automatic test_done_ext_stall;
    int st, sr, cn, er;
    logic [31:0] ca, cb;
    logic cs, to;
    logic [63:0] e;
    exp_q.push_back(64'h00000000_00000064);
    run_div(3'd2, 32'd1000, 32'd10, 5, -1, 6, 3, 0, st, sr, cn, er, ca, cb, cs, to);
    e = exp_q.pop_front();
    n_chk++; if (to !== 1'b0) $display("FAIL doneext_hang: got %b exp 0", to); else n_pass++;
    n_chk++; if (st !== 6) $display("FAIL doneext_stall_cycles: got %0d exp 6", st); else n_pass++;
    n_chk++; if (er !== 0) $display("FAIL doneext_early_write: got %0d exp 0", er); else n_pass++;
    n_chk++; if (hilo !== e) $display("FAIL doneext_hilo: got %h exp %h", hilo, e); else n_pass++;
    n_chk++; if (div_timeout !== 1'b1) $display("FAIL timeout_sticky: got %b exp 1", div_timeout); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int st, sr, cn, er;
    logic [31:0] ca, cb;
    logic cs, to;
    logic [63:0] e;
    exp_q.push_back(64'h00000001_00000002);
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFE);
    run_div(3'd3, 32'd9, 32'd4, 8, -1, -1, 0, 0, st, sr, cn, er, ca, cb, cs, to);
    e = exp_q.pop_front();
    n_chk++; if ({to, hilo} !== {1'b0, e}) $display("FAIL b2b_first: got %b/%h exp 0/%h", to, hilo, e);
    else n_pass++;
    run_div(3'd2, 32'hFFFF_FFF7, 32'd4, 8, -1, -1, 0, 0, st, sr, cn, er, ca, cb, cs, to);
    e = exp_q.pop_front();
    n_chk++; if (to !== 1'b0) $display("FAIL b2b_hang: got %b exp 0", to); else n_pass++;
    n_chk++; if (st !== 9) $display("FAIL b2b_stall_cycles: got %0d exp 9", st); else n_pass++;
    n_chk++; if ({ca, cs} !== {32'hFFFF_FFF7, 1'b1}) $display("FAIL b2b_operands: got %h/%b exp fffffff7/1", ca, cs);
    else n_pass++;
    n_chk++; if (hilo !== e) $display("FAIL b2b_second: got %h exp %h", hilo, e); else n_pass++;
  endtask

  task automatic test_div_by_zero;
    int st, sr, cn, er;
    logic [31:0] ca, cb;
    logic cs, to;
    logic [63:0] e;
    exp_q.push_back(64'h00000005_FFFFFFFF);
    run_div(3'd3, 32'd5, 32'd0, 4, -1, -1, 0, 0, st, sr, cn, er, ca, cb, cs, to);
    e = exp_q.pop_front();
    n_chk++; if ({to, cn} !== 33'd0) $display("FAIL divzero_flags: got %b/%0d exp 0/0", to, cn); else n_pass++;
    n_chk++; if (hilo !== e) $display("FAIL divzero_hilo: got %h exp %h", hilo, e); else n_pass++;
  endtask

  task automatic test_reset_mid_busy;
    op_valid_e = 1'b1; op_e = 3'd2; src_a_e = 32'd123; src_b_e = 32'd11;
    @(negedge clk);
    @(posedge clk);
    #1;
    op_valid_e = 1'b0;
    n_chk++; if ({div_start, div_sign, stall_e} !== 3'b111)
      $display("FAIL rstbusy_pre: got %b exp 111", {div_start, div_sign, stall_e}); else n_pass++;
    #1;
    rst = 1'b1;
    #1;
    n_chk++; if ({div_start, div_sign, div_cancel, div_timeout} !== 4'b0)
      $display("FAIL rstbusy_flags: got %b exp 0000", {div_start, div_sign, div_cancel, div_timeout});
    else n_pass++;
    n_chk++; if (stall_e !== 1'b0) $display("FAIL rstbusy_stall: got %b exp 0", stall_e); else n_pass++;
    n_chk++; if ({div_a, div_b} !== 64'd0) $display("FAIL rstbusy_ops: got %h exp 0", {div_a, div_b}); else n_pass++;
    n_chk++; if (hilo !== 64'd0) $display("FAIL rstbusy_hilo: got %h exp 0", hilo); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    op_valid_e = 1'b0; op_e = 3'd7; src_a_e = '0; src_b_e = '0;
    flush_e = 1'b0; stall_ext_e = 1'b0; div_done = 1'b0;
    div_result = '0; mul_result = '0;
    n_chk = 0; n_pass = 0;
    test_reset();
    test_div();
    test_divu();
    test_mult();
    test_mthi_mtlo();
    test_flush_busy();
    test_timeout();
    test_done_ext_stall();
    test_back_to_back();
    test_div_by_zero();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
